// File: rtl/ref_bank_buf_if.sv
// rtl/ref_bank_buf_if.sv - write/read handshake bundle for ref_bank_buf
//
// Write side : wr_valid/wr_ready/wr_data beats (pixel 0 in LSBs), restart and
//              swap pulses, fill_done pulse back from the buffer.
// Read side  : rd_en/rd_addr/rd_mode request, rd_data/rd_valid/rd_err result.
// master     : the producer/consumer driving requests into the buffer.
// slave      : the buffer itself.
interface ref_bank_buf_if #(
    parameter int PIXEL  = 8,
    parameter int NBANK  = 32,
    parameter int ROWS   = 8,
    parameter int DEPTH  = 96,
    parameter int IN_PIX = 32
) ();
    localparam int AW = $clog2(DEPTH);
    localparam int MW = $clog2(ROWS + 1);

    logic                          wr_valid;
    logic                          wr_ready;
    logic [IN_PIX*PIXEL-1:0]       wr_data;
    logic                          restart;
    logic                          swap;
    logic                          fill_done;
    logic                          rd_en;
    logic [AW-1:0]                 rd_addr;
    logic [MW-1:0]                 rd_mode;
    logic [NBANK*ROWS*PIXEL-1:0]   rd_data;
    logic                          rd_valid;
    logic                          rd_err;

    modport master (
        output wr_valid, wr_data, restart, swap, rd_en, rd_addr, rd_mode,
        input  wr_ready, fill_done, rd_data, rd_valid, rd_err
    );

    modport slave (
        input  wr_valid, wr_data, restart, swap, rd_en, rd_addr, rd_mode,
        output wr_ready, fill_done, rd_data, rd_valid, rd_err
    );
endinterface

// File: rtl/ref_bank_buf.sv
// rtl/ref_bank_buf.sv - banked reference-window buffer with row-select reads
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : ref_bank_buf_if.slave (write beats, restart/swap, reads)
//
// Storage is NBANK banks, each DEPTH words of ROWS pixels. A write beat lands
// in IN_PIX/ROWS adjacent banks at the current word address; the address runs
// 0..DEPTH-1 then the bank group advances. After the last beat of the last
// group the buffer is full and stops accepting beats until restart (or swap).
//
// Reads take two cycles: cycle 1 validates the request and reads every bank
// at the same word address, cycle 2 formats either the full window (mode 0)
// or one pixel row across all banks (mode r) into the output register.
//
// Build option REF_BANK_PINGPONG_EN: two pages. Writes go to the fill page,
// reads to the other page; swap while full exchanges them. Without it there is
// a single page which becomes readable at the end of the first fill.
module ref_bank_buf #(
    parameter int PIXEL  = 8,
    parameter int NBANK  = 32,
    parameter int ROWS   = 8,
    parameter int DEPTH  = 96,
    parameter int IN_PIX = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    ref_bank_buf_if.slave  bus
);
    localparam int WW   = ROWS * PIXEL;            // bank word width
    localparam int BPB  = IN_PIX / ROWS;           // banks written per beat
    localparam int NGRP = NBANK * ROWS / IN_PIX;   // bank groups per fill
    localparam int AW   = $clog2(DEPTH);
    localparam int MW   = $clog2(ROWS + 1);
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int DW   = NBANK * WW;
`ifdef REF_BANK_PINGPONG_EN
    localparam int NPAGE = 2;
`else
    localparam int NPAGE = 1;
`endif

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [GW-1:0] LAST_GRP  = GW'(NGRP - 1);
    localparam logic [AW:0]   DEPTH_X   = (AW + 1)'(DEPTH);
    localparam logic [MW-1:0] ROWS_M    = MW'(ROWS);

    // ------------------------------------------------------------------
    // Fill control
    // ------------------------------------------------------------------
    logic [AW-1:0] wr_addr;
    logic [GW-1:0] wr_grp;
    logic          full;
    logic          fill_done_q;
    logic          page_ok;     // read page holds a complete window
    logic          fill_pg;     // page receiving write beats
    logic          rd_pg;       // page serving reads
    logic          wr_fire;

    // restart takes priority: a beat offered in the same cycle is dropped
    assign wr_fire = bus.wr_valid && !full && !bus.restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr     <= '0;
            wr_grp      <= '0;
            full        <= 1'b0;
            fill_done_q <= 1'b0;
            page_ok     <= 1'b0;
`ifdef REF_BANK_PINGPONG_EN
            fill_pg     <= 1'b0;
`endif
        end else begin
            fill_done_q <= 1'b0;
            if (bus.restart) begin
                wr_addr <= '0;
                wr_grp  <= '0;
                full    <= 1'b0;
`ifndef REF_BANK_PINGPONG_EN
                // the single page is being overwritten from scratch
                page_ok <= 1'b0;
`endif
            end else if (wr_fire) begin
                if (wr_addr == LAST_ADDR) begin
                    wr_addr <= '0;
                    if (wr_grp == LAST_GRP) begin
                        wr_grp      <= '0;
                        full        <= 1'b1;
                        fill_done_q <= 1'b1;
`ifndef REF_BANK_PINGPONG_EN
                        page_ok     <= 1'b1;
`endif
                    end else begin
                        wr_grp <= wr_grp + 1'b1;
                    end
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end
`ifdef REF_BANK_PINGPONG_EN
            else if (bus.swap && full) begin
                // freshly filled page becomes the read page; old read page
                // is recycled for the next fill
                fill_pg <= ~fill_pg;
                full    <= 1'b0;
                page_ok <= 1'b1;
            end
`endif
        end
    end

`ifdef REF_BANK_PINGPONG_EN
    assign rd_pg = ~fill_pg;
`else
    assign fill_pg = 1'b0;
    assign rd_pg   = 1'b0;
`endif

    assign bus.wr_ready  = !full;
    assign bus.fill_done = fill_done_q;

    // ------------------------------------------------------------------
    // Read stage 1: validate request, read all banks
    // ------------------------------------------------------------------
    logic          rd_ok;
    logic [AW-1:0] rd_addr_safe;
    logic          s1_valid;
    logic          s1_err;
    logic [MW-1:0] s1_mode;
    logic [DW-1:0] s1_words;

    assign rd_ok = ({1'b0, bus.rd_addr} < DEPTH_X) && (bus.rd_mode <= ROWS_M) && page_ok;
    // keep the array index in range even for rejected requests
    assign rd_addr_safe = rd_ok ? bus.rd_addr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_mode  <= '0;
        end else begin
            s1_valid <= bus.rd_en && rd_ok;
            s1_err   <= bus.rd_en && !rd_ok;
            if (bus.rd_en) begin
                s1_mode <= bus.rd_mode;
            end
        end
    end

    // One storage array per bank. The read page is latched into word_q in the
    // request cycle, so a later swap cannot affect reads already issued, and a
    // same-cycle write to the same word is seen only by subsequent reads.
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        localparam logic [GW-1:0] MY_GRP = GW'(b / BPB);
        localparam int            SLOT   = b % BPB;

        logic [WW-1:0] mem [NPAGE][DEPTH];
        logic [WW-1:0] word_q;

        always_ff @(posedge clk) begin
            if (wr_fire && (wr_grp == MY_GRP)) begin
                mem[fill_pg][wr_addr] <= bus.wr_data[SLOT*WW +: WW];
            end
            if (bus.rd_en) begin
                word_q <= mem[rd_pg][rd_addr_safe];
            end
        end

        assign s1_words[b*WW +: WW] = word_q;
    end

    // ------------------------------------------------------------------
    // Read stage 2: format and register the result
    // ------------------------------------------------------------------
    logic [DW-1:0] fmt_data;

    always_comb begin
        fmt_data = '0;
        if (s1_mode == '0) begin
            fmt_data = s1_words;
        end else begin
            // mode r picks pixel r-1 of every bank, packed bank 0 first
            for (int r = 0; r < ROWS; r++) begin
                if (s1_mode == MW'(r + 1)) begin
                    for (int b = 0; b < NBANK; b++) begin
                        fmt_data[b*PIXEL +: PIXEL] = s1_words[b*WW + r*PIXEL +: PIXEL];
                    end
                end
            end
        end
    end

    logic [DW-1:0] rd_data_q;
    logic          rd_valid_q;
    logic          rd_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= s1_valid;
            rd_err_q   <= s1_err;
            rd_data_q  <= s1_valid ? fmt_data : '0;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_err   = rd_err_q;
endmodule

// File: tb/tb_ref_bank_buf.sv
// tb/tb_ref_bank_buf.sv - scoreboard bench for ref_bank_buf (single-page build)
module tb_ref_bank_buf;
    localparam int PIXEL  = 8;
    localparam int NBANK  = 32;
    localparam int ROWS   = 8;
    localparam int DEPTH  = 96;
    localparam int IN_PIX = 32;
    localparam int WW     = ROWS * PIXEL;
    localparam int DW     = NBANK * WW;
    localparam int BW     = IN_PIX * PIXEL;
    localparam int BPB    = IN_PIX / ROWS;
    localparam int NBEAT  = DEPTH * NBANK * ROWS / IN_PIX;
    localparam int AW     = $clog2(DEPTH);
    localparam int MW     = $clog2(ROWS + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;
    bit   page_ok_m = 1'b0;
    int   seed    = 0;

    typedef struct {
        int            due;
        logic          v;
        logic          e;
        logic [DW-1:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    ref_bank_buf_if #(.PIXEL(PIXEL), .NBANK(NBANK), .ROWS(ROWS), .DEPTH(DEPTH), .IN_PIX(IN_PIX)) bus ();

    ref_bank_buf #(.PIXEL(PIXEL), .NBANK(NBANK), .ROWS(ROWS), .DEPTH(DEPTH), .IN_PIX(IN_PIX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pix(int s, int n, int p);
        return 8'((n * 3 + p * 29 + s * 101) % 256);
    endfunction

    function automatic logic [BW-1:0] beat(int s, int n);
        logic [BW-1:0] d;
        d = '0;
        for (int p = 0; p < IN_PIX; p++) d[p*PIXEL +: PIXEL] = pix(s, n, p);
        return d;
    endfunction

    // bank b, word a holds beat (b/BPB)*DEPTH+a, pixels (b%BPB)*ROWS .. +ROWS-1
    function automatic logic [DW-1:0] exp_read(int s, int a, int m);
        logic [DW-1:0] d;
        int n;
        int p;
        d = '0;
        for (int b = 0; b < NBANK; b++) begin
            n = (b / BPB) * DEPTH + a;
            for (int k = 0; k < ROWS; k++) begin
                p = (b % BPB) * ROWS + k;
                if (m == 0) d[(b*ROWS + k)*PIXEL +: PIXEL] = pix(s, n, p);
                else if (k == m - 1) d[b*PIXEL +: PIXEL] = pix(s, n, p);
            end
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        int b;
        b = 0;
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            for (int i = NBANK - 1; i >= 0; i--) if (obs[i*WW +: WW] !== exp[i*WW +: WW]) b = i;
            $error("FAIL %s: bank %0d got %h expected %h", tag, b, obs[b*WW +: WW], exp[b*WW +: WW]);
        end
    endtask

    // output monitor: due entries are compared, every other cycle must be idle
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                chk("rd_valid", bus.rd_valid, mon_e.v);
                chk("rd_err", bus.rd_err, mon_e.e);
                chk_data("rd_data", bus.rd_data, mon_e.d);
            end else begin
                chk("idle_rd_valid", bus.rd_valid, 1'b0);
                chk("idle_rd_err", bus.rd_err, 1'b0);
            end
        end
    end

    task automatic rd_req(input int a, input int m);
        exp_t e;
        bit   ok;
        logic [31:0] av;
        logic [31:0] mv;
        av = a;
        mv = m;
        @(negedge clk);
        bus.rd_en   = 1'b1;
        bus.rd_addr = av[AW-1:0];
        bus.rd_mode = mv[MW-1:0];
        ok    = page_ok_m && (a < DEPTH) && (m <= ROWS);
        e.due = cyc + 2;
        e.v   = ok;
        e.e   = !ok;
        e.d   = ok ? exp_read(seed, a, m) : '0;
        sb.push_back(e);
    endtask

    task automatic rd_stop();
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() > 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        sb.delete();
    endtask

    task automatic fill(input int s, input int nb, output int dcnt, output int dat);
        dcnt = 0;
        dat  = -1;
        for (int n = 0; n < nb; n++) begin
            @(negedge clk);
            if (bus.fill_done === 1'b1) begin
                dcnt++;
                dat = n - 1;
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = beat(s, n);
        end
        @(negedge clk);
        if (bus.fill_done === 1'b1) begin
            dcnt++;
            dat = nb - 1;
        end
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        int dcnt;
        int dat;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.restart  = 1'b0;
        bus.swap     = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        bus.rd_mode  = '0;

        repeat (3) @(negedge clk);
        chk("reset_wr_ready", bus.wr_ready, 1'b1);
        chk("reset_fill_done", bus.fill_done, 1'b0);
        chk("reset_rd_valid", bus.rd_valid, 1'b0);
        chk("reset_rd_err", bus.rd_err, 1'b0);
        chk_data("reset_rd_data", bus.rd_data, '0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // nothing filled yet: read must be rejected
        rd_req(5, 0);
        rd_stop();
        drain();

        // partial fill, then reset with a read in flight
        fill(0, 300, dcnt, dat);
        chk("partial_fill_done_count", dcnt, 0);
        rd_req(1, 0);
        @(negedge clk);
        bus.rd_en = 1'b0;
        mon_en    = 1'b0;
        rst_n     = 1'b0;
        sb.delete();
        #1;
        chk("midreset_rd_valid", bus.rd_valid, 1'b0);
        chk("midreset_rd_err", bus.rd_err, 1'b0);
        chk_data("midreset_rd_data", bus.rd_data, '0);
        chk("midreset_fill_done", bus.fill_done, 1'b0);
        chk("midreset_wr_ready", bus.wr_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // full fill from beat 0
        fill(0, NBEAT, dcnt, dat);
        chk("fill_done_count", dcnt, 1);
        chk("fill_done_beat", dat, NBEAT - 1);
        page_ok_m = 1'b1;
        @(negedge clk);
        chk("fill_done_pulse_end", bus.fill_done, 1'b0);
        chk("full_wr_ready", bus.wr_ready, 1'b0);

        // beats offered while full must not be written
        bus.wr_valid = 1'b1;
        bus.wr_data  = {BW{1'b1}};
        repeat (3) @(negedge clk);
        bus.wr_valid = 1'b0;
        chk("full_wr_ready_hold", bus.wr_ready, 1'b0);

        // directed and random back-to-back reads
        rd_req(5, 0);
        rd_req(10, 3);
        rd_req(DEPTH - 1, ROWS);
        rd_req(0, 1);
        rd_req(DEPTH, 0);
        rd_req(3, ROWS + 1);
        rd_req(DEPTH - 1, 0);
        for (int i = 0; i < 24; i++) rd_req($urandom_range(0, DEPTH + 1), $urandom_range(0, ROWS + 1));
        rd_stop();
        drain();

        // restart beats a simultaneous write beat and invalidates the page
        @(negedge clk);
        bus.restart  = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = {BW{1'b1}};
        @(negedge clk);
        bus.restart  = 1'b0;
        bus.wr_valid = 1'b0;
        chk("restart_wr_ready", bus.wr_ready, 1'b1);
        page_ok_m = 1'b0;
        rd_req(5, 0);
        rd_stop();
        drain();

        // refill with new data
        seed = 1;
        fill(1, NBEAT, dcnt, dat);
        chk("refill_done_count", dcnt, 1);
        chk("refill_done_beat", dat, NBEAT - 1);
        page_ok_m = 1'b1;
        rd_req(0, 0);
        rd_req(DEPTH - 1, 0);
        rd_req(40, ROWS);
        rd_req(7, 1);
        rd_stop();
        drain();

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ref_bank_buf.md
REF_BANK_BUF -- requirements
Module: ref_bank_buf

Interface
REQ-001 Parameter PIXEL, 8, bits per pixel.
REQ-002 Parameter NBANK, 32, number of banks (window width in pixels).
REQ-003 Parameter ROWS, 8, pixels per bank word (rows read per access).
REQ-004 Parameter DEPTH, 96, words per bank.
REQ-005 Parameter IN_PIX, 32, pixels per write beat; IN_PIX multiple of ROWS, NBANK*ROWS multiple of IN_PIX.
REQ-006 clk  in  1  clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 wr_valid  in  1  write beat offered.
REQ-009 wr_ready  out  1  write beat accepted when wr_valid&wr_ready.
REQ-010 wr_data  in  IN_PIX*PIXEL  write beat, pixel 0 in LSBs.
REQ-011 restart  in  1  pulse: clear fill counters and full flag.
REQ-012 swap  in  1  pulse: exchange fill/read pages (ping-pong builds only).
REQ-013 fill_done  out  1  one-cycle pulse on last beat of a window fill.
REQ-014 rd_en  in  1  read request.
REQ-015 rd_addr  in  clog2(DEPTH)  bank word address.
REQ-016 rd_mode  in  clog2(ROWS+1)  0 = all rows, r = row r only (1..ROWS).
REQ-017 rd_data  out  NBANK*ROWS*PIXEL  read result.
REQ-018 rd_valid  out  1  rd_data valid (all-rows or single-row).
REQ-019 rd_err  out  1  one-cycle pulse: rejected read (bad mode/address/no valid page).

Function
REQ-020 Beat b of group g writes word wr_addr into banks g*(IN_PIX/ROWS)+i, i=0..IN_PIX/ROWS-1, slice i*ROWS*PIXEL of wr_data.
REQ-021 wr_addr counts 0..DEPTH-1 per accepted beat; on wrap g increments; NGRP = NBANK*ROWS/IN_PIX groups per fill.
REQ-022 Accepting beat (wr_addr=DEPTH-1, g=NGRP-1) pulses fill_done next cycle, sets full, wraps counters to 0.
REQ-023 wr_ready = !full; beats offered while full are not written.
REQ-024 Bank word pixel k = row k+1 of that bank's column; all-rows rd_data = concatenation of bank words, bank 0 in LSBs.
REQ-025 Read latency 2: rd_en at cycle t -> rd_data/rd_valid at t+2; back-to-back reads every cycle.
REQ-026 Single-row mode r: rd_data[NBANK*PIXEL-1:0] = pixel r-1 of every bank (bank 0 LSB); upper bits zero.
REQ-027 rd_valid deasserted cycles: rd_data holds zero.
REQ-028 rd_mode>ROWS or rd_addr>=DEPTH or no valid read page: no rd_valid, rd_err pulses at t+2.
REQ-029 Same-cycle write and read of same bank/address return old data (read-before-write).
REQ-030 restart wins over a simultaneous write beat; that beat is dropped.

Reset
REQ-031 On rst_n low: counters 0, full 0, fill_done 0, rd_valid 0, rd_err 0, rd_data 0, read pipeline flushed; bank contents undefined.
REQ-032 Reset mid-fill or mid-read discards in-flight operations; no rd_valid after release for pre-reset requests.

Configuration
REQ-033 Macro REF_BANK_PINGPONG_EN defined: two pages; writes target fill page, reads target read page; swap while full exchanges pages, clears full, marks read page valid; swap while !full ignored; swap with rd_en in flight: reads issued before swap complete from old page.
REQ-034 Macro undefined: single page, read page valid once first fill_done occurs until restart or reset; swap ignored.

Verification
REQ-035 Default params, fill 768 beats ramp data -> fill_done once on beat 768, wr_ready low after.
REQ-036 After fill, rd_en addr 5 mode 0 -> rd_valid at t+2, rd_data = 32 bank words at address 5.
REQ-037 rd_mode 3 addr 10 -> low 256 bits = pixel 2 of each bank, upper 1792 bits zero.
REQ-038 rd_mode 9 or rd_addr 96 -> rd_err at t+2, rd_valid 0.
REQ-039 PINGPONG_EN: fill A, swap, fill B while reading -> reads return A data until second swap, then B.
REQ-040 rst_n asserted mid-fill beat 300 -> outputs zero, refill from beat 0 gives fill_done at beat 768.
